// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and the default bit period,
// kept here so a future transmitter can reuse them.
package uart_pkg;

    // 12 MHz system clock / 115200 baud
    localparam int unsigned UART_CLOCKS_PER_BIT_DEFAULT = 104;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        START     = ST_START,
        DATA      = ST_DATA,
        PARITY    = ST_PARITY,
        STOP      = ST_STOP,
        WAIT_HIGH = ST_WAIT_HIGH
    } uart_state_t;

    // High when byte plus received parity bit do not form even parity
    function automatic logic even_parity_bad(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for the asynchronous RX line. Both flops reset to 1
// so the line looks idle while reset is applied.
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    // Double-register the asynchronous input
    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB-first, 1 stop bit, with a one-entry holding
// register (valid/ready), framing error pulse and sticky overrun flag.
// Optional even parity bit is enabled by defining UART_RX_PARITY_EN; without
// it the frame is 8N1 and parity_error is tied low.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT_DEFAULT  // 8..65535
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       parity_error
);

    localparam logic [15:0] HALF_COUNT = 16'(CLOCKS_PER_BIT / 2);
    localparam logic [15:0] LAST_COUNT = 16'(CLOCKS_PER_BIT - 1);

    logic        w_rx_s;
    logic        w_par_ok;

    uart_state_t r_state;
    logic [15:0] r_count;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_framing_error;
    logic        r_overrun;
    logic        r_rx_prev;
    logic [1:0]  r_settle;
`ifdef UART_RX_PARITY_EN
    logic        r_parity_error;
    logic        r_par_bad;
`endif

    sync2 u_sync2 (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (w_rx_s)
    );

`ifdef UART_RX_PARITY_EN
    assign w_par_ok     = ~r_par_bad;
    assign parity_error = r_parity_error;
`else
    assign w_par_ok     = 1'b1;
    assign parity_error = 1'b0;
`endif

    assign data          = r_data;
    assign valid         = r_valid;
    assign framing_error = r_framing_error;
    assign overrun       = r_overrun;

    // Receive FSM, edge detector and holding register with registered flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_count         <= 16'd0;
            r_bit_idx       <= 3'd0;
            r_data          <= 8'h00;
            r_valid         <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
            r_rx_prev       <= 1'b0;
            r_settle        <= 2'd0;
`ifdef UART_RX_PARITY_EN
            r_parity_error  <= 1'b0;
            r_par_bad       <= 1'b0;
`endif
        end else begin
            r_framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_error  <= 1'b0;
`endif
            // The synchronizer's forced-high reset value would otherwise look
            // like a falling edge when the line is already low after reset, so
            // edge history only starts once real samples reach rx_s.
            if (r_settle != 2'd2) begin
                r_settle <= r_settle + 2'd1;
            end else begin
                r_rx_prev <= w_rx_s;
            end

            // Consumer handshake; a byte loaded below in the same cycle wins
            if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (r_rx_prev && !w_rx_s) begin
                        r_state <= START;
                        r_count <= 16'd0;
                    end
                end
                START: begin
                    if (r_count == HALF_COUNT) begin
                        r_count   <= 16'd0;
                        r_bit_idx <= 3'd0;
                        r_state   <= w_rx_s ? IDLE : DATA;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                DATA: begin
                    if (r_count == LAST_COUNT) begin
                        r_count <= 16'd0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_count == LAST_COUNT) begin
                        r_count        <= 16'd0;
                        r_par_bad      <= even_parity_bad(r_shift, w_rx_s);
                        r_parity_error <= even_parity_bad(r_shift, w_rx_s);
                        r_state        <= STOP;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (r_count == LAST_COUNT) begin
                        r_count <= 16'd0;
                        if (w_rx_s) begin
                            r_state <= IDLE;
                            if (w_par_ok) begin
                                if (!r_valid || ready) begin
                                    r_data  <= r_shift;
                                    r_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end
                        end else begin
                            r_framing_error <= 1'b1;
                            r_state         <= WAIT_HIGH;
                        end
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 104, meaning clock cycles per bit (12 MHz / 115200 baud); legal range 8..65535.
REQ-002 SHALL have port clock, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning the reset: synchronous, active-high.
REQ-004 SHALL have port rx, input, 1, meaning the asynchronous serial line from the board RX pin (idle high).
REQ-005 SHALL have port data, output, 8, meaning the received byte, valid while valid=1.
REQ-006 SHALL have port valid, output, 1, meaning the holding register contains an unconsumed byte.
REQ-007 SHALL have port ready, input, 1, meaning the consumer accepts data this cycle.
REQ-008 SHALL have port framing_error, output, 1, meaning a one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL have port overrun, output, 1, meaning sticky: a byte completed while the holding register was full.
REQ-010 SHALL have port parity_error, output, 1, meaning a one-cycle pulse on parity mismatch (see Configuration).

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 SHALL implement the states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH, using one bit-timer counter 0..CLOCKS_PER_BIT-1 and a 3-bit bit index.
REQ-013 SHALL leave IDLE for START only on a 1->0 transition of rx_s; a line already low does not start a frame.
REQ-014 SHALL, in START at count CLOCKS_PER_BIT/2 (integer division), go to DATA if rx_s=0, else return to IDLE (glitch rejection, no flags).
REQ-015 SHALL sample each data bit at one full CLOCKS_PER_BIT interval after the previous sample point, shifting LSB-first; after bit index 7 it goes to PARITY (macro defined) or STOP.
REQ-016 SHALL, in STOP when rx_s=1 at the sample point, load the shift register into data and set valid the next cycle, then go to IDLE; latency from stop-bit sample point to valid=1 is 1 cycle.
REQ-017 SHALL, in STOP when rx_s=0 at the sample point, pulse framing_error for 1 cycle, discard the byte and go to WAIT_HIGH, which exits to IDLE when rx_s=1.
REQ-018 SHALL keep valid and data stable until a cycle with valid=1 and ready=1; valid clears the following cycle unless a new byte loads in the same cycle.
REQ-019 SHALL, when a byte completes and the holding register is full, not take it as a simultaneous consume (valid=1 and ready=1): it loads the new byte and valid stays 1 with no overrun.
REQ-020 SHALL, when a byte completes while the holding register is full and not consumed that cycle, drop the new byte, keep the old data and set overrun until reset.
REQ-021 SHALL ignore ready while valid=0.

Reset
REQ-022 SHALL set, on reset=1 at a clock edge: state IDLE, counters 0, valid=0, data=0x00, framing_error=0, overrun=0, parity_error=0, synchronizer flops=1.
REQ-023 SHALL discard any partial frame on reset asserted mid-frame; after reset, a start requires a fresh 1->0 edge.

Configuration
REQ-024 SHALL, with UART_RX_PARITY_EN defined, receive one even-parity bit after bit 7 in PARITY; on mismatch it pulses parity_error and still checks the stop bit, but does not load the byte.
REQ-025 SHALL, without UART_RX_PARITY_EN, omit the PARITY state and logic; the frame is 8N1 and parity_error is tied 0.

Structure
REQ-026 SHALL place the state encoding localparams and the default CLOCKS_PER_BIT constant in shared package uart_pkg, for reuse by a future uart_tx.
REQ-027 SHALL implement the synchronizer as sub-module sync2 (clock, reset, d, q; reset value 1); all other logic stays in uart_rx.

Verification (CLOCKS_PER_BIT=104)
REQ-028 SHALL cover: 8N1 frame 0xA5 with ready=1 -> valid=1 for 1 cycle with data=0xA5, and no flags.
REQ-029 SHALL cover: rx low pulse of 30 cycles from idle -> no valid and no flags; state back to IDLE.
REQ-030 SHALL cover: frame 0x3C with stop bit low, then line high -> framing_error pulses once, valid stays 0, and next frame 0x01 is received correctly.
REQ-031 SHALL cover: frames 0x11 then 0x22 with ready=0 -> data=0x11 held and overrun=1; then ready=1 -> 0x11 consumed and valid=0.
REQ-032 SHALL cover: reset asserted at bit 4 of a frame, rx held low through reset release -> no byte, no start until rx rises and falls again.
REQ-033 SHALL cover, with UART_RX_PARITY_EN: frame 0x07 with parity bit 0 (wrong) -> parity_error pulse and no valid; with parity bit 1 -> data=0x07 and valid=1.
